// File: rtl/divider_prog.sv
// divider_prog: runtime-programmable integer clock divider.
// Divides i_clk by N (2..2^W-1); a new N is captured into a pending register
// and applied only at a period boundary, so o_div_clk never shows a runt pulse.
// N == 0 stops the divider with o_div_clk and o_tick held low.
// Optional macro DIVP_ODD_DUTY50_EN adds a negedge flop that stretches the
// high phase of odd divisors by half a cycle, giving 50% duty for odd N.
module divider_prog #(
    parameter int W        = 8,
    parameter int DIV_INIT = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_div_val,
    input  logic         i_div_load,
    output logic         o_div_clk,
    output logic         o_tick,
    output logic [W-1:0] o_cur_div,
    output logic         o_pend,
    output logic         o_err
);

    // A divisor of 1 cannot be produced; it is promoted to 2 and flagged.
    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] v);
        return (v == W'(1)) ? W'(2) : v;
    endfunction

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    logic         div_clk_q, div_clk_d;
    logic         tick_q, tick_d;
    logic         apply;

    // Next-state: counter wrap, boundary apply of the pending divisor, load capture,
    // and output decode of the current count (outputs lag the count by one cycle).
    always_comb begin
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        // A strobe in the boundary cycle overrides the older pending value,
        // which is then dropped in favour of the new one at the following boundary.
        apply      = pend_q && !i_div_load;

        if (cur_div_q == '0) begin
            cnt_d = '0;
            if (apply) begin
                cur_div_d = pend_div_q;
                pend_d    = 1'b0;
            end
        end else if (cnt_q == cur_div_q - W'(1)) begin
            cnt_d = '0;
            if (apply) begin
                cur_div_d = pend_div_q;
                pend_d    = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + W'(1);
        end

        if (i_div_load) begin
            pend_div_d = clamp_div(i_div_val);
            pend_d     = 1'b1;
            err_d      = (i_div_val == W'(1));
        end

        div_clk_d = (cnt_q < (cur_div_q >> 1));
        tick_d    = (cnt_q == '0) && (cur_div_q != '0);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            cur_div_q <= W'(DIV_INIT);
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    // Pending divisor value; only meaningful while pend_q is set.
    always_ff @(posedge i_clk) begin
        pend_div_q <= pend_div_d;
    end

`ifdef DIVP_ODD_DUTY50_EN
    logic odd_q;
    logic neg_q;

    // Oddness of the divisor that produced the current div_clk_q value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= cur_div_q[0];
        end
    end

    // Half-cycle delayed copy of the high phase, used only for odd divisors.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= div_clk_q & odd_q;
        end
    end

    assign o_div_clk = div_clk_q | neg_q;
`else
    assign o_div_clk = div_clk_q;
`endif

    assign o_tick    = tick_q;
    assign o_cur_div = cur_div_q;
    assign o_pend    = pend_q;
    assign o_err     = err_q;

endmodule
